// File: rtl/dino_regs_pkg.sv
// Shared constants and types for the display register writer.
// Index map mirrors the VGA display register file.
package dino_regs_pkg;

    localparam int NUM_REGS  = 13;
    localparam int DATA_W    = 10;
    localparam int BASE_ADDR = 0;
    localparam int AV_ADDR_W = 9;
    localparam int IDX_W     = $clog2(NUM_REGS);

    localparam int REG_DINO_X   = 0;
    localparam int REG_DINO_Y   = 1;
    localparam int REG_JUMP_X   = 2;
    localparam int REG_JUMP_Y   = 3;
    localparam int REG_DUCK_X   = 4;
    localparam int REG_DUCK_Y   = 5;
    localparam int REG_CACTUS_X = 6;
    localparam int REG_CACTUS_Y = 7;
    localparam int REG_GODZ_X   = 8;
    localparam int REG_GODZ_Y   = 9;
    localparam int REG_SCORE    = 10;
    localparam int REG_SCORE_X  = 11;
    localparam int REG_SCORE_Y  = 12;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE,
        DONE
    } wr_state_t;

endpackage

// File: rtl/dino_frame_reg_writer_if.sv
// Avalon-MM write-only bus between the frame writer and the display.
// Master drives the request, slave answers with waitrequest.
interface dino_frame_reg_writer_if #(
    parameter int AV_ADDR_W = 9
);
    logic [AV_ADDR_W-1:0] av_address;
    logic [31:0]          av_writedata;
    logic                 av_write;
    logic                 av_chipselect;
    logic                 av_waitrequest;

    modport master (
        output av_address,
        output av_writedata,
        output av_write,
        output av_chipselect,
        input  av_waitrequest
    );

    modport slave (
        input  av_address,
        input  av_writedata,
        input  av_write,
        input  av_chipselect,
        output av_waitrequest
    );
endinterface

// File: rtl/vsync_edge_sync.sv
// Two-flop synchroniser with a registered falling-edge pulse.
// Pulse appears 3 clk after the pin edge; also used for the game tick.
module vsync_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sig_n_i,
    output logic fall_o
);
    logic s1_q, s2_q, s3_q, fall_q;

    // Reset low so a pin already high at release gives no pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= sig_n_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            fall_q <= s3_q & ~s2_q;
        end
    end

    assign fall_o = fall_q;
endmodule

// File: rtl/dino_frame_reg_writer.sv
// Shadows sprite/score registers and flushes dirty entries to the
// display over Avalon-MM once per vertical sync.
module dino_frame_reg_writer
    import dino_regs_pkg::*;
#(
    parameter int NUM_REGS  = dino_regs_pkg::NUM_REGS,
    parameter int DATA_W    = dino_regs_pkg::DATA_W,
    parameter int BASE_ADDR = dino_regs_pkg::BASE_ADDR,
    parameter int AV_ADDR_W = dino_regs_pkg::AV_ADDR_W,
    localparam int IW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_vs_n,
    input  logic              upd_valid,
    input  logic [IW-1:0]     upd_idx,
    input  logic [DATA_W-1:0] upd_data,
    input  logic              force_all,
    input  logic              overrun_clr,
    dino_frame_reg_writer_if.master av,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

    wr_state_t state_q, state_d;

    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic [DATA_W-1:0]   snap_q   [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q, dirty_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [IW-1:0]       cur_idx_q, cur_idx_d;
    logic                overrun_q, overrun_d;

    logic vs_start;
    logic upd_hit;
    logic take_frame;
    logic av_write;
    logic accept;

    function automatic logic [IW-1:0] lowest_set(
        input logic [NUM_REGS-1:0] v
    );
        logic [IW-1:0] r;
        r = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    vsync_edge_sync u_vs_sync (
        .clk     (clk),
        .reset   (reset),
        .sig_n_i (vga_vs_n),
        .fall_o  (vs_start)
    );

    assign upd_hit    = upd_valid && (upd_idx <= LAST_IDX);
    assign take_frame = (state_q == IDLE) && vs_start;
    assign accept     = av_write && !av.av_waitrequest;

    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        frame_done = 1'b0;
        av_write   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vs_start) state_d = SCAN;
            end
            SCAN: begin
                if (|pending_q) begin
                    cur_idx_d = lowest_set(pending_q);
                    state_d   = WRITE;
                end else begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                av_write = 1'b1;
                if (!av.av_waitrequest) state_d = SCAN;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A force_all or update landing with the snapshot re-dirties
    // for the following frame.
    always_comb begin
        dirty_d = dirty_q;
        if (take_frame) dirty_d = '0;
        if (force_all) dirty_d = '1;
        if (upd_hit) dirty_d[upd_idx] = 1'b1;
    end

    always_comb begin
        pending_d = pending_q;
        if (take_frame) pending_d = dirty_q;
        if (accept) pending_d[cur_idx_q] = 1'b0;
    end

    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) overrun_d = 1'b0;
        if (vs_start && state_q != IDLE) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dirty_q   <= '0;
            pending_q <= '0;
            cur_idx_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            cur_idx_q <= cur_idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Snapshot takes the pre-update shadow value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                snap_q[i]   <= '0;
            end
        end else begin
            if (take_frame) snap_q <= shadow_q;
            if (upd_hit) shadow_q[upd_idx] <= upd_data;
        end
    end

    assign av.av_write      = av_write;
    assign av.av_chipselect = av_write;
    assign av.av_address    = av_write
        ? AV_ADDR_W'(BASE_ADDR) + AV_ADDR_W'(cur_idx_q)
        : '0;
    assign av.av_writedata  = av_write
        ? 32'(snap_q[cur_idx_q])
        : 32'd0;

    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;
endmodule

// File: tb/tb_dino_frame_reg_writer.sv
// Directed bench for the frame register writer.
// Slave model stalls each write a configurable number of cycles.
module tb_dino_frame_reg_writer;
    logic       clk = 1'b0;
    logic       reset;
    logic       vga_vs_n;
    logic       upd_valid;
    logic [3:0] upd_idx;
    logic [9:0] upd_data;
    logic       force_all;
    logic       overrun_clr;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    dino_frame_reg_writer_if #(.AV_ADDR_W(9)) av_bus ();

    dino_frame_reg_writer dut (
        .clk         (clk),
        .reset       (reset),
        .vga_vs_n    (vga_vs_n),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_idx),
        .upd_data    (upd_data),
        .force_all   (force_all),
        .overrun_clr (overrun_clr),
        .av          (av_bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_cfg = 0;
    int stall_cnt = 0;
    int stab_err = 0;
    int cs_err = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    int busy_cyc = 0;
    logic [8:0]  hold_addr;
    logic [31:0] hold_data;
    logic [8:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    logic [9:0]  exp_sh [13];

    always @(posedge clk) cyc++;

    // Slave model and bus observer.
    always @(negedge clk) begin
        if (av_bus.av_chipselect !== av_bus.av_write) cs_err++;
        if (av_bus.av_write) begin
            if (stall_cnt > 0 &&
                (av_bus.av_address !== hold_addr ||
                 av_bus.av_writedata !== hold_data))
                stab_err++;
            hold_addr = av_bus.av_address;
            hold_data = av_bus.av_writedata;
            if (stall_cnt < stall_cfg) begin
                av_bus.av_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                av_bus.av_waitrequest = 1'b0;
                wr_addr.push_back(av_bus.av_address);
                wr_data.push_back(av_bus.av_writedata);
                stall_cnt = 0;
            end
        end else begin
            av_bus.av_waitrequest = 1'b0;
            stall_cnt = 0;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (busy) busy_cyc++;
    end

    task automatic post_upd(input logic [3:0] idx,
                            input logic [9:0] data);
        @(negedge clk); #1;
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_data  = data;
        if (idx < 13) exp_sh[idx] = data;
        @(negedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic pulse_force();
        @(negedge clk); #1;
        force_all = 1'b1;
        @(negedge clk); #1;
        force_all = 1'b0;
    endtask

    // Drops the pin, optionally injects an update at cycle c0+inj_off
    // or re-triggers vsync at c0+refall, waits for frame_done.
    task automatic run_vsync(input int inj_off,
                             input logic [3:0] inj_idx,
                             input logic [9:0] inj_data,
                             input int refall,
                             output int lat);
        int c0;
        int fd0;
        bit tmo;
        wr_addr.delete();
        wr_data.delete();
        fd0 = fd_cnt;
        @(negedge clk); #1;
        busy_cyc = 0;
        vga_vs_n = 1'b0;
        c0 = cyc;
        tmo = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk); #1;
            upd_valid = 1'b0;
            if (inj_off != 0 && cyc == c0 + inj_off) begin
                upd_valid = 1'b1;
                upd_idx   = inj_idx;
                upd_data  = inj_data;
                exp_sh[inj_idx] = inj_data;
            end
            if (refall != 0 && cyc == c0 + 8) vga_vs_n = 1'b1;
            if (refall != 0 && cyc == c0 + refall) vga_vs_n = 1'b0;
            if (fd_cnt != fd0) begin
                tmo = 1'b0;
                break;
            end
        end
        upd_valid = 1'b0;
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL frame_timeout: frame_done not seen in 300 clk");
        end
        lat = fd_cyc - c0;
        vga_vs_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all_regs(input string nm);
        checks++;
        if (wr_addr.size() !== 13) begin
            errors++;
            $display("FAIL %s_count: got %0d expected 13",
                     nm, wr_addr.size());
        end
        for (int i = 0; i < 13 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== 9'(i) ||
                wr_data[i] !== {22'd0, exp_sh[i]}) begin
                errors++;
                $display("FAIL %s_%0d: got a=%0d d=%h expected a=%0d d=%h",
                         nm, i, wr_addr[i], wr_data[i], i, exp_sh[i]);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (av_bus.av_write !== 1'b0 || av_bus.av_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL reset_write: got %b/%b expected 0/0",
                     av_bus.av_write, av_bus.av_chipselect);
        end
        checks++;
        if (av_bus.av_address !== 9'd0 || av_bus.av_writedata !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: got %h/%h expected 0/0",
                     av_bus.av_address, av_bus.av_writedata);
        end
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got %b%b%b expected 000",
                     busy, frame_done, overrun);
        end
    endtask

    task automatic test_no_updates();
        int lat;
        run_vsync(0, 4'd0, 10'd0, 0, lat);
        check_int("clean_writes", wr_addr.size(), 0);
        check_int("clean_latency", lat, 5);
        check_int("clean_busy", busy_cyc, 2);
    endtask

    task automatic test_two_updates();
        int lat;
        post_upd(4'd1, 10'h064);
        post_upd(4'd0, 10'h032);
        post_upd(4'd13, 10'h3FF);
        run_vsync(0, 4'd0, 10'd0, 0, lat);
        check_int("two_count", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check_int("two_a0", int'(wr_addr[0]), 0);
            check_int("two_d0", int'(wr_data[0]), 'h32);
            check_int("two_a1", int'(wr_addr[1]), 1);
            check_int("two_d1", int'(wr_data[1]), 'h64);
        end
        check_int("two_latency", lat, 9);
        check_int("two_busy", busy_cyc, 6);
        run_vsync(0, 4'd0, 10'd0, 0, lat);
        check_int("two_dirty_cleared", wr_addr.size(), 0);
    endtask

    task automatic test_force_stall();
        int lat;
        stall_cfg = 3;
        stab_err = 0;
        pulse_force();
        run_vsync(0, 4'd0, 10'd0, 0, lat);
        check_all_regs("force");
        check_int("force_latency", lat, 70);
        check_int("force_stable", stab_err, 0);
        stall_cfg = 0;
    endtask

    task automatic test_snap_race();
        int lat;
        post_upd(4'd5, 10'd3);
        run_vsync(3, 4'd5, 10'd7, 0, lat);
        check_int("race_count", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check_int("race_addr", int'(wr_addr[0]), 5);
            check_int("race_old", int'(wr_data[0]), 3);
        end
        run_vsync(0, 4'd0, 10'd0, 0, lat);
        check_int("race_next_count", wr_addr.size(), 1);
        if (wr_addr.size() == 1)
            check_int("race_new", int'(wr_data[0]), 7);
    endtask

    task automatic test_overrun();
        int lat;
        int fd0;
        stall_cfg = 3;
        stab_err = 0;
        pulse_force();
        run_vsync(0, 4'd0, 10'd0, 20, lat);
        fd0 = fd_cnt;
        check_all_regs("ovr");
        check_int("ovr_latency", lat, 70);
        check_int("ovr_stable", stab_err, 0);
        check_int("ovr_flag", int'(overrun), 1);
        repeat (10) @(negedge clk);
        #1;
        check_int("ovr_no_extra_frame", fd_cnt - fd0, 0);
        check_int("ovr_sticky", int'(overrun), 1);
        overrun_clr = 1'b1;
        @(negedge clk); #1;
        overrun_clr = 1'b0;
        check_int("ovr_clr", int'(overrun), 0);
        stall_cfg = 0;
    endtask

    task automatic test_reset_midwrite();
        int lat;
        bit seen;
        stall_cfg = 3;
        post_upd(4'd3, 10'h155);
        @(negedge clk); #1;
        vga_vs_n = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); #1;
            if (av_bus.av_write) begin
                seen = 1'b1;
                break;
            end
        end
        check_int("rst_write_seen", int'(seen), 1);
        reset = 1'b1;
        #1;
        check_int("rst_write_drop", int'(av_bus.av_write), 0);
        check_int("rst_busy_drop", int'(busy), 0);
        for (int i = 0; i < 13; i++) exp_sh[i] = '0;
        vga_vs_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        stall_cfg = 0;
        repeat (6) @(negedge clk);
        #1;
        check_int("rst_busy_after", int'(busy), 0);
        run_vsync(0, 4'd0, 10'd0, 0, lat);
        check_int("rst_no_writes", wr_addr.size(), 0);
        check_int("rst_clean_latency", lat, 5);
        pulse_force();
        run_vsync(0, 4'd0, 10'd0, 0, lat);
        check_all_regs("rst_shadow");
        check_int("chipselect_eq_write", cs_err, 0);
    endtask

    initial begin
        reset       = 1'b1;
        vga_vs_n    = 1'b1;
        upd_valid   = 1'b0;
        upd_idx     = '0;
        upd_data    = '0;
        force_all   = 1'b0;
        overrun_clr = 1'b0;
        av_bus.av_waitrequest = 1'b0;
        for (int i = 0; i < 13; i++) exp_sh[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        test_reset();
        test_no_updates();
        test_two_updates();
        test_force_stall();
        test_snap_race();
        test_overrun();
        test_reset_midwrite();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
